note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Parametrised successor of the 3-bit JK-counter + 3:8 decoder note player.
//  Steps a synchronous note index through CHANNELS buzzer lines and holds each note STEP_DIV clocks.
//  Provides start/stop control, up/down direction, single-shot or loop mode and a done pulse.
//  Sits between the top-level control inputs and the buzzer output elements.
// PARAMETERS
//  CHANNELS    8    number of buzzer outputs / notes (2..64, need not be a power of two)
//  STEP_DIV    16   clock cycles each note is held (>=1)
//  IDX_W       $clog2(CHANNELS)  note index width (derived localparam)
//  TONE_BASE   32   TONE_EN only: half-period in clocks for note 0
//  TONE_STEP   2    TONE_EN only: half-period decrement per index step
//                   constraint: TONE_BASE - (CHANNELS-1)*TONE_STEP >= 1
// PORTS
//  clk       in   1         single clock, rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  start     in   1         1-cycle request to begin a sequence
//  stop      in   1         abort the current sequence
//  loop_en   in   1         1 = wrap and repeat; 0 = single pass
//  dir       in   1         0 = ascending index, 1 = descending (latched at start)
//  buzzer    out  CHANNELS  one-hot active note line; all-zero when idle
//  note_idx  out  IDX_W     index of the current note
//  busy      out  1         high while in PLAY
//  done      out  1         1-cycle pulse at the end of a single-shot pass
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately): state=IDLE, buzzer=0, note_idx=0, busy=0, done=0,
//    prescaler=0, latched dir=0.
//  - States: IDLE, PLAY. All outputs are registered.
//  - IDLE + start=1 (stop=0) -> PLAY on the next edge.
//      note_idx = 0 (dir=0) or CHANNELS-1 (dir=1); prescaler=0; busy=1; dir is latched.
//      First note is visible 1 cycle after start.
//  - PLAY: buzzer = one-hot(note_idx). The prescaler counts 0..STEP_DIV-1; each note lasts
//    exactly STEP_DIV cycles.
//  - Prescaler terminal, not the last note: idx +1 (up) or -1 (down); prescaler=0.
//  - Prescaler terminal, last note (CHANNELS-1 going up, 0 going down):
//      loop_en=1 -> wrap to the first note. There is no gap cycle; loop_en is sampled at this edge only.
//      loop_en=0 -> IDLE, buzzer=0, busy=0, note_idx holds the last value, done=1 for one cycle.
//  - Index wrap honours CHANNELS that are not a power of two; the index never exceeds CHANNELS-1.
//  - stop=1 in PLAY -> IDLE on the next edge, buzzer=0, busy=0, done stays 0.
//  - start while busy is ignored; changes to dir while busy are ignored.
//  - start and stop asserted in the same cycle: stop wins, and start is discarded in either state.
//  - Reset asserted mid-sequence: immediate return to the reset values. A start must be asserted
//    after rst_n deasserts to resume.
//  - Sequence length = CHANNELS*STEP_DIV cycles from the first note to the done pulse.
// CONFIGURATION
//  - TONE_GEN_EN defined:
//      The active buzzer bit is a square wave, not a steady level.
//      Half-period = TONE_BASE - note_idx*TONE_STEP clocks.
//      Phase restarts high on every note change and on entry to PLAY.
//      Inactive lines are 0. The tone counter is reset to 0 by rst_n.
//  - TONE_GEN_EN undefined:
//      The active buzzer bit is steady 1 for the whole note.
//      No tone counter logic is synthesised, and TONE_BASE/TONE_STEP are unused.
// TESTING
//  1. Reset, CHANNELS=8, STEP_DIV=4, start pulse with dir=0, loop_en=0 -> buzzer 0x01,0x02..0x80,
//     4 cycles each; done=1 exactly 32 cycles after the first note; then buzzer=0, busy=0.
//  2. dir=1, loop_en=1 -> sequence 0x80..0x01, then wraps to 0x80 with no idle cycle;
//     done is never asserted.
//  3. stop at cycle 10 of PLAY -> next cycle buzzer=0, busy=0, done=0;
//     a later start replays from note 0.
//  4. CHANNELS=5 -> note_idx runs 0..4 then wraps to 0; never 5..7;
//     start+stop in the same cycle in IDLE -> stays IDLE.
//  5. Assert rst_n=0 mid-note -> all outputs 0 immediately, without waiting for clk;
//     start pulse while busy -> no restart, timing unchanged.
//  6. TONE_GEN_EN, TONE_BASE=8, TONE_STEP=2 -> note 0 toggles every 8 clocks, note 3 every 2 clocks;
//     phase is high at each note start.

Source files
------------

// File: rtl/note_sequencer.sv
// Note sequencer: steps a one-hot buzzer line through CHANNELS notes, STEP_DIV clocks each.
// Optional square-wave tone per note when TONE_GEN_EN is defined.
module note_sequencer #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned STEP_DIV  = 16,
    parameter int unsigned TONE_BASE = 32,
    parameter int unsigned TONE_STEP = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop_en,
    input  logic                        dir,
    output logic [CHANNELS-1:0]         buzzer,
    output logic [$clog2(CHANNELS)-1:0] note_idx,
    output logic                        busy,
    output logic                        done
);
    localparam int unsigned IDX_W = $clog2(CHANNELS);
    localparam int unsigned PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CHANNELS - 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(STEP_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CHANNELS-1:0]   buzzer_q, buzzer_d;
    logic [CHANNELS-1:0]   onehot_d;
    logic                  note_start;
    logic                  last_note;

    assign last_note = dir_q ? (idx_q == '0) : (idx_q == IDX_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        presc_d    = presc_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        note_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = PLAY;
                    idx_d      = dir ? IDX_LAST : '0;
                    presc_d    = '0;
                    dir_d      = dir;
                    note_start = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d    = '0;
                    note_start = 1'b1;
                    if (last_note) begin
                        if (loop_en) begin
                            idx_d = dir_q ? IDX_LAST : '0;
                        end else begin
                            state_d    = IDLE;
                            done_d     = 1'b1;
                            note_start = 1'b0;
                        end
                    end else begin
                        idx_d = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == PLAY);
    end

    always_comb begin
        onehot_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            onehot_d[i] = (idx_d == IDX_W'(i));
        end
    end

`ifdef TONE_GEN_EN
    localparam int unsigned TW = $clog2(TONE_BASE + 1);

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] half_m1;

    // Half-period of the note currently playing, minus one for terminal compare.
    assign half_m1 = TW'(TONE_BASE) - TW'(idx_q) * TW'(TONE_STEP) - 1'b1;

    always_comb begin
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        if (!busy_d) begin
            tone_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (note_start) begin
            tone_cnt_d = '0;
            phase_d    = 1'b1;
        end else if (tone_cnt_q == half_m1) begin
            tone_cnt_d = '0;
            phase_d    = ~phase_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
        end
        buzzer_d = (busy_d && phase_d) ? onehot_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
        end
    end
`else
    assign buzzer_d = busy_d ? onehot_d : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            presc_q  <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            buzzer_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer   = buzzer_q;
    assign note_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: an 8-channel and a 5-channel instance, default build.
module tb_note_sequencer;
    typedef struct {
        logic [7:0] buz;
        logic [5:0] idx;
        bit         idx_chk;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stop = 1'b0, loop_en = 1'b0, dir = 1'b0;
    logic [7:0] buzzer;
    logic [2:0] note_idx;
    logic       busy, done;

    logic       c5_start = 1'b0, c5_stop = 1'b0, c5_loop = 1'b0, c5_dir = 1'b0;
    logic [4:0] c5_buzzer;
    logic [2:0] c5_idx;
    logic       c5_busy, c5_done;

    exp_t q8[$];
    exp_t q5[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    note_sequencer #(.CHANNELS(8), .STEP_DIV(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en), .dir(dir),
        .buzzer(buzzer), .note_idx(note_idx), .busy(busy), .done(done)
    );

    note_sequencer #(.CHANNELS(5), .STEP_DIV(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(c5_start), .stop(c5_stop), .loop_en(c5_loop), .dir(c5_dir),
        .buzzer(c5_buzzer), .note_idx(c5_idx), .busy(c5_busy), .done(c5_done)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_q(input int d, input exp_t e);
        if (d == 8) q8.push_back(e);
        else        q5.push_back(e);
    endtask

    // Expected notes for the first ncyc cycles of a pass (wrapping into later passes).
    task automatic push_notes(input int d, input bit dr, input int ncyc, input int nch, input int sdiv);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            int n  = (c / sdiv) % nch;
            int ix = dr ? nch - 1 - n : n;
            e.buz     = 8'h01 << ix;
            e.idx     = 6'(ix);
            e.idx_chk = 1'b1;
            e.busy    = 1'b1;
            e.done    = 1'b0;
            push_q(d, e);
        end
    endtask

    task automatic push_idle(input int d, input int n, input bit ichk, input int ix, input bit dn);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.buz     = 8'h00;
            e.idx     = 6'(ix);
            e.idx_chk = ichk;
            e.busy    = 1'b0;
            e.done    = (c == 0) ? dn : 1'b0;
            push_q(d, e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("c8_buzzer", buzzer, e.buz);
            if (e.idx_chk) chk("c8_idx", {5'b0, note_idx}, {2'b0, e.idx});
            chk("c8_busy", {7'b0, busy}, {7'b0, e.busy});
            chk("c8_done", {7'b0, done}, {7'b0, e.done});
        end
        if (q5.size() != 0) begin
            e = q5.pop_front();
            chk("c5_buzzer", {3'b0, c5_buzzer}, e.buz);
            if (e.idx_chk) chk("c5_idx", {5'b0, c5_idx}, {2'b0, e.idx});
            chk("c5_busy", {7'b0, c5_busy}, {7'b0, e.busy});
            chk("c5_done", {7'b0, c5_done}, {7'b0, e.done});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_buzzer", buzzer, 8'h00);
        chk("rst_idx", {5'b0, note_idx}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(8, 1, 1'b1, 0, 1'b0);
        step();

        // Ascending single pass: 8 notes x 4 cycles, done then idle
        start = 1'b1; dir = 1'b0; loop_en = 1'b0;
        push_notes(8, 1'b0, 32, 8, 4);
        push_idle(8, 3, 1'b1, 7, 1'b1);
        step();
        start = 1'b0;
        run(34);

        // Descending loop: two passes with seamless wrap; dir change while busy ignored
        start = 1'b1; dir = 1'b1; loop_en = 1'b1;
        push_notes(8, 1'b1, 64, 8, 4);
        step();
        start = 1'b0; dir = 1'b0;
        run(63);
        stop = 1'b1;
        push_idle(8, 1, 1'b0, 0, 1'b0);
        step();
        stop = 1'b0; loop_en = 1'b0;

        // Stop after 10 cycles of play, start+stop together in IDLE
        start = 1'b1;
        push_notes(8, 1'b0, 10, 8, 4);
        step();
        start = 1'b0;
        run(9);
        stop = 1'b1;
        push_idle(8, 1, 1'b0, 0, 1'b0);
        step();
        start = 1'b1;
        push_idle(8, 2, 1'b0, 0, 1'b0);
        step();
        start = 1'b0; stop = 1'b0;
        step();

        // Replay from note 0; a start pulse while busy leaves timing unchanged
        start = 1'b1;
        push_notes(8, 1'b0, 32, 8, 4);
        push_idle(8, 2, 1'b1, 7, 1'b1);
        step();
        start = 1'b0;
        run(5);
        start = 1'b1;
        step();
        start = 1'b0;
        run(27);

        // Five channels: index wraps 4 -> 0, then start+stop in IDLE stays idle
        c5_start = 1'b1; c5_loop = 1'b1; c5_dir = 1'b0;
        push_notes(5, 1'b0, 20, 5, 2);
        push_idle(5, 3, 1'b0, 0, 1'b0);
        push_idle(8, 23, 1'b1, 7, 1'b0);
        step();
        c5_start = 1'b0;
        run(19);
        c5_stop = 1'b1;
        step();
        c5_start = 1'b1;
        step();
        c5_start = 1'b0; c5_stop = 1'b0;
        step();

        // Asynchronous reset in the middle of a note
        start = 1'b1;
        push_notes(8, 1'b0, 6, 8, 4);
        step();
        start = 1'b0;
        run(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_buzzer", buzzer, 8'h00);
        chk("arst_idx", {5'b0, note_idx}, 8'h00);
        chk("arst_busy", {7'b0, busy}, 8'h00);
        chk("arst_done", {7'b0, done}, 8'h00);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(8, 3, 1'b1, 0, 1'b0);
        run(3);

        chk("q8_drained", 8'(q8.size()), 8'h00);
        chk("q5_drained", 8'(q5.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
